// File: rtl/sc_fifo_9x128w_18x64r_pkg.sv
// Shared constants and payload types for the 9-to-18 bit upsizing FIFO.
package fifo_pkg;

  localparam int unsigned PushWidth     = 9;
  localparam int unsigned PopWidth      = 18;
  localparam int unsigned Depth         = 128;
  localparam int unsigned AddrWidth     = 7;
  localparam int unsigned CountWidth    = 8;
  // Count is evaluated one bit wider so push/pop arithmetic never wraps
  localparam int unsigned CountCalcWidth = CountWidth + 1;
  localparam int unsigned BankDepth     = Depth / 2;
  localparam int unsigned BankAddrWidth = AddrWidth - 1;
  // A pop needs one full output word's worth of push entries
  localparam int unsigned EmptyThresh   = PopWidth / PushWidth;

  typedef logic [PushWidth-1:0] push_word_t;

  // Popped word: earlier-pushed entry in the upper half
  typedef struct packed {
    push_word_t hi;
    push_word_t lo;
  } pop_word_t;

endpackage

// File: rtl/sc_fifo_9x128w_18x64r_regbank.sv
// 64x9 simple dual-port register bank: synchronous write, asynchronous read.
module sdp_regbank_64x9
  import fifo_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [BankAddrWidth-1:0] waddr_i,
  input  push_word_t               wdata_i,
  input  logic [BankAddrWidth-1:0] raddr_i,
  output push_word_t               rdata_o_c
);

  push_word_t mem_q [BankDepth];

  // Storage write; contents are never cleared, the pointers guard stale data
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o_c = mem_q[raddr_i];

endmodule

// File: rtl/sc_fifo_9x128w_18x64r.sv
// Single-clock FIFO: 9-bit pushes reassembled into 18-bit pops, 128 entries deep.
module sc_fifo_9x128w_18x64r
  import fifo_pkg::*;
(
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [PushWidth-1:0]  iPushData,
  input  logic                  iPushEnable,
  output logic                  oIsFull,
  output logic [PopWidth-1:0]   oPopData,
  input  logic                  iPopEnable,
  output logic                  oIsEmpty,
  output logic [CountWidth-1:0] oDataCount
);

  logic [AddrWidth-1:0]      wptr_q, wptr_d;
  // Read pointer is always even, so only the pair index is kept
  logic [BankAddrWidth-1:0]  rpair_q, rpair_d;
  logic [CountWidth-1:0]     count_q;
  logic [CountCalcWidth-1:0] count_d;
  logic                      full_q, full_d;
  logic                      empty_q, empty_d;
  pop_word_t                 pop_data_q, pop_data_d;

  logic       push_ok_c, pop_ok_c;
  logic       we_even_c, we_odd_c;
  push_word_t even_rdata_c, odd_rdata_c;

  // Accept requests against the registered (pre-edge) flags
  always_comb begin
    push_ok_c = iPushEnable & ~full_q;
    pop_ok_c  = iPopEnable & ~empty_q;
    we_even_c = push_ok_c & ~wptr_q[0] & ~iReset;
    we_odd_c  = push_ok_c &  wptr_q[0] & ~iReset;
  end

  sdp_regbank_64x9 u_even_bank (
    .clk_i     (iClock),
    .we_i      (we_even_c),
    .waddr_i   (wptr_q[AddrWidth-1:1]),
    .wdata_i   (iPushData),
    .raddr_i   (rpair_q),
    .rdata_o_c (even_rdata_c)
  );

  sdp_regbank_64x9 u_odd_bank (
    .clk_i     (iClock),
    .we_i      (we_odd_c),
    .waddr_i   (wptr_q[AddrWidth-1:1]),
    .wdata_i   (iPushData),
    .raddr_i   (rpair_q),
    .rdata_o_c (odd_rdata_c)
  );

  // Next pointers, count, flags and output word
  always_comb begin
    wptr_d     = wptr_q;
    rpair_d    = rpair_q;
    pop_data_d = pop_data_q;
    count_d    = CountCalcWidth'(count_q);

    if (push_ok_c) begin
      wptr_d  = wptr_q + AddrWidth'(1);
      count_d = count_d + CountCalcWidth'(1);
    end
    if (pop_ok_c) begin
      rpair_d       = rpair_q + BankAddrWidth'(1);
      count_d       = count_d - CountCalcWidth'(EmptyThresh);
      pop_data_d.hi = even_rdata_c;
      pop_data_d.lo = odd_rdata_c;
    end

    full_d  = (count_d == CountCalcWidth'(Depth));
    empty_d = (count_d <  CountCalcWidth'(EmptyThresh));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wptr_q     <= '0;
      rpair_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      pop_data_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rpair_q    <= rpair_d;
      count_q    <= CountWidth'(count_d);
      full_q     <= full_d;
      empty_q    <= empty_d;
      pop_data_q <= pop_data_d;
    end
  end

  assign oIsFull    = full_q;
  assign oIsEmpty   = empty_q;
  assign oDataCount = count_q;
  assign oPopData   = pop_data_q;

endmodule

// File: tb/tb_sc_fifo_9x128w_18x64r.sv
// Self-checking bench for the 9-to-18 bit upsizing FIFO.
module tb_sc_fifo_9x128w_18x64r;

  logic        iClock;
  logic        iReset;
  logic [8:0]  iPushData;
  logic        iPushEnable;
  logic        oIsFull;
  logic [17:0] oPopData;
  logic        iPopEnable;
  logic        oIsEmpty;
  logic [7:0]  oDataCount;

  sc_fifo_9x128w_18x64r dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iPushData   (iPushData),
    .iPushEnable (iPushEnable),
    .oIsFull     (oIsFull),
    .oPopData    (oPopData),
    .iPopEnable  (iPopEnable),
    .oIsEmpty    (oIsEmpty),
    .oDataCount  (oDataCount)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: FIFO of 9-bit entries plus the last popped word
  logic [8:0]  q[$];
  logic [17:0] m_pop = '0;

  typedef struct {
    logic        rst;
    logic        push;
    logic [8:0]  d;
    logic        pop;
    logic [7:0]  cnt;
    logic        emp;
    logic        ful;
    logic [17:0] pd;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model by the same request
  task automatic step(input logic rst, input logic push, input logic [8:0] d, input logic pop);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == 128);
    was_empty = (q.size() < 2);
    iReset = rst; iPushEnable = push; iPushData = d; iPopEnable = pop;
    if (rst) begin
      q.delete();
      m_pop = '0;
    end else begin
      if (pop && !was_empty) begin
        m_pop = {q[0], q[1]};
        void'(q.pop_front());
        void'(q.pop_front());
      end
      if (push && !was_full) q.push_back(d);
    end
    @(posedge iClock);
    #1;
    iReset = 1'b0; iPushEnable = 1'b0; iPopEnable = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 18'(oDataCount), 18'(q.size()));
    check({tag, ".empty"}, 18'(oIsEmpty), 18'(q.size() < 2));
    check({tag, ".full"},  18'(oIsFull),  18'(q.size() == 128));
    check({tag, ".data"},  oPopData, m_pop);
  endtask

  function automatic vec_t mk(logic rst, logic push, logic [8:0] d, logic pop,
                              logic [7:0] cnt, logic emp, logic ful, logic [17:0] pd);
    vec_t v;
    v.rst = rst; v.push = push; v.d = d; v.pop = pop;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.pd = pd;
    return v;
  endfunction

  initial begin
    logic [8:0]  a, b;
    logic [17:0] pair;
    int          guard;

    iReset = 1'b0; iPushEnable = 1'b0; iPopEnable = 1'b0; iPushData = '0;

    // Directed vectors: basic pair, then odd occupancy (A=011 B=122 C=0F3 D=1E4)
    tbl[0]  = mk(1, 0, 9'h000, 0, 8'd0, 1, 0, 18'h00000);
    tbl[1]  = mk(0, 1, 9'h1A5, 0, 8'd1, 1, 0, 18'h00000);
    tbl[2]  = mk(0, 1, 9'h04C, 0, 8'd2, 0, 0, 18'h00000);
    tbl[3]  = mk(0, 0, 9'h000, 1, 8'd0, 1, 0, 18'h34A4C);
    tbl[4]  = mk(0, 1, 9'h011, 0, 8'd1, 1, 0, 18'h34A4C);
    tbl[5]  = mk(0, 1, 9'h122, 0, 8'd2, 0, 0, 18'h34A4C);
    tbl[6]  = mk(0, 1, 9'h0F3, 0, 8'd3, 0, 0, 18'h34A4C);
    tbl[7]  = mk(0, 0, 9'h000, 1, 8'd1, 1, 0, 18'h02322);
    tbl[8]  = mk(0, 0, 9'h000, 1, 8'd1, 1, 0, 18'h02322);
    tbl[9]  = mk(0, 1, 9'h1E4, 0, 8'd2, 0, 0, 18'h02322);
    tbl[10] = mk(0, 0, 9'h000, 1, 8'd0, 1, 0, 18'h1E7E4);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].push, tbl[i].d, tbl[i].pop);
      check($sformatf("vec%0d.count", i), 18'(oDataCount), 18'(tbl[i].cnt));
      check($sformatf("vec%0d.empty", i), 18'(oIsEmpty),   18'(tbl[i].emp));
      check($sformatf("vec%0d.full", i),  18'(oIsFull),    18'(tbl[i].ful));
      check($sformatf("vec%0d.data", i),  oPopData,        tbl[i].pd);
    end

    // Fill with 0..129; the last two pushes must be dropped
    for (int i = 0; i < 130; i++) begin
      step(0, 1, 9'(i), 0);
      check($sformatf("fill%0d.count", i), 18'(oDataCount), 18'((i < 128) ? i + 1 : 128));
      check($sformatf("fill%0d.full", i),  18'(oIsFull),    18'(i >= 127));
    end
    for (int k = 0; k < 64; k++) begin
      step(0, 0, '0, 1);
      a = 9'(2 * k); b = 9'(2 * k + 1);
      pair = {a, b};
      check($sformatf("drain%0d.data", k),  oPopData, pair);
      check($sformatf("drain%0d.count", k), 18'(oDataCount), 18'(126 - 2 * k));
    end
    check("drain.empty", 18'(oIsEmpty), 18'(1));

    // Count 2 with push and pop together: pair leaves, new entry stays
    step(0, 1, 9'h0AA, 0);
    step(0, 1, 9'h155, 0);
    step(0, 1, 9'h0F0, 1);
    check("sim2.count", 18'(oDataCount), 18'(1));
    check("sim2.empty", 18'(oIsEmpty),   18'(1));
    check("sim2.data",  oPopData,        18'h15555);
    step(0, 1, 9'h00F, 0);
    step(0, 0, '0, 1);
    check("sim2.next", oPopData, 18'h1E00F);

    // Count 128 with push and pop together: push dropped, one pair leaves
    for (int i = 0; i < 128; i++) step(0, 1, 9'(i + 3), 0);
    check("sim128.full_before", 18'(oIsFull), 18'(1));
    step(0, 1, 9'h1FF, 1);
    check("sim128.count", 18'(oDataCount), 18'(126));
    check("sim128.full",  18'(oIsFull),    18'(0));
    a = 9'd3; b = 9'd4; pair = {a, b};
    check("sim128.data",  oPopData, pair);
    for (int k = 0; k < 63; k++) step(0, 0, '0, 1);
    a = 9'd129; b = 9'd130; pair = {a, b};
    check("sim128.last",  oPopData, pair);
    check("sim128.empty", 18'(oIsEmpty), 18'(1));

    // Random traffic across pointer wrap, checked every cycle against the model
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 99) < 55), 9'($urandom), (q.size() >= 2) && $urandom_range(0, 1) == 1);
      check_model($sformatf("rnd%0d", i));
    end

    // Reach count 57, then reset together with push and pop
    guard = 0;
    while (q.size() != 57 && guard < 400) begin
      if (q.size() < 57) step(0, 1, 9'($urandom), 0);
      else               step(0, 0, '0, 1);
      guard++;
    end
    check("mid.count57", 18'(oDataCount), 18'(57));
    step(1, 1, 9'h1C3, 1);
    check("rst.count", 18'(oDataCount), 18'(0));
    check("rst.empty", 18'(oIsEmpty),   18'(1));
    check("rst.full",  18'(oIsFull),    18'(0));
    check("rst.data",  oPopData,        18'h00000);
    step(0, 0, '0, 1);
    check_model("rst.popempty");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 9'(9'h100 + i), 0);
      check_model($sformatf("post%0d", i));
    end
    step(0, 0, '0, 1);
    check("post.pop1", oPopData, 18'h20101);
    step(0, 0, '0, 1);
    check("post.pop2", oPopData, 18'h20503);
    check_model("post.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
